// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the core-side data-memory bus master.
package mem_bus_pkg;

   typedef enum logic [1:0] {
      SZ_WORD = 2'b00,
      SZ_HALF = 2'b01,
      SZ_BYTE = 2'b10
   } size_e;

   typedef enum logic [1:0] {
      IDLE,
      BUS,
      RESP
   } state_e;

   // Console and simulation-exit addresses; the bus master treats them as ordinary stores.
   localparam logic [31:0] STDOUT_ADDR = 32'hf000_0000;
   localparam logic [31:0] EXIT_ADDR   = 32'hff00_0000;

   // The unused size code 2'b11 behaves as a byte access everywhere.
   function automatic size_e norm_size(input logic [1:0] sz);
      size_e r;
      if (sz == 2'b11) r = SZ_BYTE;
      else             r = size_e'(sz);
      return r;
   endfunction

   function automatic logic is_misaligned(input size_e sz, input logic [1:0] lsb);
      logic r;
      if (sz == SZ_WORD)      r = (lsb != 2'b00);
      else if (sz == SZ_HALF) r = lsb[0];
      else                    r = 1'b0;
      return r;
   endfunction

endpackage

// File: rtl/bus_load_align.sv
// Combinational data steering: sign/zero extension of load data and
// right-alignment (zero fill) of store data for word/half/byte accesses.
module bus_load_align
   import mem_bus_pkg::*;
#(
   parameter int unsigned BIT_WIDTH = 32
) (
   input  logic [1:0]           ld_size_i,
   input  logic                 ld_unsigned_i,
   input  logic [BIT_WIDTH-1:0] load_raw_i,
   input  logic [1:0]           st_size_i,
   input  logic [BIT_WIDTH-1:0] store_raw_i,
   output logic [BIT_WIDTH-1:0] load_ext_o,
   output logic [BIT_WIDTH-1:0] store_aln_o
);

   logic sext;

   always_comb begin
      sext       = !ld_unsigned_i;
      load_ext_o = load_raw_i;
      case (norm_size(ld_size_i))
         SZ_HALF: load_ext_o = {{(BIT_WIDTH-16){sext & load_raw_i[15]}}, load_raw_i[15:0]};
         SZ_BYTE: load_ext_o = {{(BIT_WIDTH-8){sext & load_raw_i[7]}}, load_raw_i[7:0]};
         default: load_ext_o = load_raw_i;
      endcase
   end

   always_comb begin
      store_aln_o = store_raw_i;
      case (norm_size(st_size_i))
         SZ_HALF: store_aln_o = {{(BIT_WIDTH-16){1'b0}}, store_raw_i[15:0]};
         SZ_BYTE: store_aln_o = {{(BIT_WIDTH-8){1'b0}}, store_raw_i[7:0]};
         default: store_aln_o = store_raw_i;
      endcase
   end

endmodule

// File: rtl/dmem_bus_master.sv
// Core-side initiator for the external data-memory bus: one bus transfer per
// load/store request, with misalignment and acknowledge-timeout reporting.
module dmem_bus_master
   import mem_bus_pkg::*;
#(
   parameter int unsigned BIT_WIDTH   = 32,
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_write,
   input  logic [1:0]           req_size,
   input  logic                 req_unsigned,
   input  logic [BIT_WIDTH-1:0] req_addr,
   input  logic [BIT_WIDTH-1:0] req_wdata,
   output logic                 resp_valid,
   output logic [BIT_WIDTH-1:0] resp_rdata,
   output logic                 resp_err,
   output logic [BIT_WIDTH-1:0] DAD,
   output logic                 MREQ,
   output logic                 WRITE,
   output logic [1:0]           SIZE,
   inout  wire  [BIT_WIDTH-1:0] DDT,
   input  logic                 ACKD_n
);

   localparam int unsigned CNT_W = (ACK_TIMEOUT == 0) ? 1 : $clog2(ACK_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(ACK_TIMEOUT);

   state_e               state_q, state_d;
   logic [BIT_WIDTH-1:0] addr_q, addr_d;
   logic                 write_q, write_d;
   size_e                size_q, size_d;
   logic                 uns_q, uns_d;
   logic [BIT_WIDTH-1:0] wdata_q, wdata_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 resp_valid_q, resp_valid_d;
   logic                 resp_err_q, resp_err_d;
   logic [BIT_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
   logic                 mreq_q, mreq_d;
   logic                 bus_wr_q, bus_wr_d;
   logic                 ready_q, ready_d;

   size_e                req_size_n;
   logic [CNT_W-1:0]     cnt_inc;
   logic [BIT_WIDTH-1:0] load_ext;
   logic [BIT_WIDTH-1:0] store_aln;

   assign req_size_n = norm_size(req_size);
   assign cnt_inc    = cnt_q + CNT_W'(1);

   bus_load_align #(
      .BIT_WIDTH (BIT_WIDTH)
   ) u_align (
      .ld_size_i     (size_q),
      .ld_unsigned_i (uns_q),
      .load_raw_i    (DDT),
      .st_size_i     (req_size),
      .store_raw_i   (req_wdata),
      .load_ext_o    (load_ext),
      .store_aln_o   (store_aln)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         write_q      <= 1'b0;
         size_q       <= SZ_WORD;
         uns_q        <= 1'b0;
         wdata_q      <= '0;
         cnt_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
         mreq_q       <= 1'b0;
         bus_wr_q     <= 1'b0;
         ready_q      <= 1'b1;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         write_q      <= write_d;
         size_q       <= size_d;
         uns_q        <= uns_d;
         wdata_q      <= wdata_d;
         cnt_q        <= cnt_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
         mreq_q       <= mreq_d;
         bus_wr_q     <= bus_wr_d;
         ready_q      <= ready_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      write_d      = write_q;
      size_d       = size_q;
      uns_d        = uns_q;
      wdata_d      = wdata_q;
      cnt_d        = cnt_q;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      resp_rdata_d = '0;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (is_misaligned(req_size_n, req_addr[1:0])) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else begin
                  state_d = BUS;
                  addr_d  = req_addr;
                  write_d = req_write;
                  size_d  = req_size_n;
                  uns_d   = req_unsigned;
                  wdata_d = store_aln;
                  cnt_d   = '0;
               end
            end
         end
         BUS: begin
            // An acknowledge arriving on the timeout edge still completes cleanly.
            if (!ACKD_n) begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_rdata_d = write_q ? '0 : load_ext;
            end else if ((ACK_TIMEOUT != 0) && (cnt_inc == CNT_LIMIT)) begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b1;
            end else if (ACK_TIMEOUT != 0) begin
               cnt_d = cnt_inc;
            end
         end
         RESP: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: state_d = IDLE;
      endcase

      // Bus-facing outputs are decoded from the next state so they come straight off flops.
      mreq_d   = (state_d == BUS);
      bus_wr_d = (state_d == BUS) && write_d;
      ready_d  = (state_d == IDLE);
   end

   assign req_ready  = ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rdata_q;
   assign DAD        = addr_q;
   assign MREQ       = mreq_q;
   assign WRITE      = bus_wr_q;
   assign SIZE       = size_q;
   assign DDT        = bus_wr_q ? wdata_q : 'z;

endmodule

// File: tb/tb_dmem_bus_master.sv
// Self-checking bench for dmem_bus_master: directed vector table, hand-written
// timeout/abort sequences and randomized transfers against a byte-array memory model.
module tb_dmem_bus_master;

   localparam logic [31:0] KEEP = 32'h5a5a_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_write, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] DAD;
   logic        MREQ, WRITE, ACKD_n;
   logic [1:0]  SIZE;
   wire  [31:0] DDT;
   logic        mem_oe;
   logic [31:0] mem_drv;

   int checks = 0;
   int errors = 0;

   // mem[0] is the reference image, mem[1] the image seen by the bus-side memory.
   logic [7:0] mem [2][64];

   assign DDT = mem_oe ? mem_drv : 'z;

   always #5 clk = ~clk;

   dmem_bus_master #(
      .BIT_WIDTH   (32),
      .ACK_TIMEOUT (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .DAD          (DAD),
      .MREQ         (MREQ),
      .WRITE        (WRITE),
      .SIZE         (SIZE),
      .DDT          (DDT),
      .ACKD_n       (ACKD_n)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'b00) ? 4 : (sz == 2'b01) ? 2 : 1;
   endfunction

   function automatic logic [31:0] mask_of(input int n);
      return (n == 4) ? 32'hffff_ffff : ((32'd1 << (8 * n)) - 32'd1);
   endfunction

   // Big-endian: the lowest address is the most significant byte of the right-aligned value.
   function automatic logic [31:0] mem_get(input int sel, input logic [31:0] a, input logic [1:0] sz);
      logic [31:0] v = '0;
      for (int i = 0; i < nbytes(sz); i++)
         v = (v << 8) | 32'(mem[sel][(int'(a[5:0]) + i) % 64]);
      return v;
   endfunction

   task automatic mem_put(input int sel, input logic [31:0] a, input logic [1:0] sz, input logic [31:0] v);
      int n = nbytes(sz);
      for (int i = 0; i < n; i++)
         mem[sel][(int'(a[5:0]) + i) % 64] = 8'(v >> (8 * (n - 1 - i)));
   endtask

   function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
      int n = nbytes(sz);
      logic [31:0] v = mem_get(0, a, sz);
      if (!uns && n < 4 && v[8 * n - 1]) v = v | ~mask_of(n);
      return v;
   endfunction

   task automatic run_xfer(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata, input int wt,
                           input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                           input int exp_bus, input logic [1:0] exp_size, input logic [31:0] exp_ddt);
      int          lat = 1;
      int          nbus = 0;
      logic        fields_ok = 1'b1;
      logic        ddt_ok = 1'b1;
      logic        seen = 1'b0;
      logic        mreq_at_resp = 1'b1;
      logic [31:0] got_rdata = 32'hdead_dead;
      logic        got_err = 1'b0;
      logic [31:0] v;
      int          n;
      chk({tag, "_ready_in"}, req_ready, 1);
      req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata; ACKD_n = 1'b1; mem_oe = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      while (!seen && lat <= 64) begin
         if (resp_valid) begin
            seen = 1'b1; got_rdata = resp_rdata; got_err = resp_err; mreq_at_resp = MREQ;
         end else begin
            if (MREQ) begin
               nbus++;
               if (DAD !== addr || WRITE !== wr || SIZE !== exp_size || req_ready !== 1'b0) fields_ok = 1'b0;
               if (wr && DDT !== exp_ddt) ddt_ok = 1'b0;
               if (nbus > wt) begin
                  ACKD_n = 1'b0;
                  if (wr) begin
                     mem_put(1, DAD, SIZE, DDT);
                  end else begin
                     n = nbytes(SIZE);
                     v = mem_get(1, DAD, SIZE);
                     mem_drv = v | ($urandom & ~mask_of(n));
                     mem_oe = 1'b1;
                  end
               end
            end
            @(posedge clk); #1;
            lat++;
         end
      end
      chk({tag, "_resp_seen"}, seen, 1);
      chk({tag, "_latency"}, lat, exp_lat);
      chk({tag, "_bus_cycles"}, nbus, exp_bus);
      chk({tag, "_err"}, got_err, exp_err);
      chk({tag, "_rdata"}, got_rdata, exp_rdata);
      chk({tag, "_bus_fields"}, fields_ok, 1);
      chk({tag, "_ddt"}, ddt_ok, 1);
      chk({tag, "_mreq_at_resp"}, mreq_at_resp, 0);
      ACKD_n = 1'b1; mem_oe = 1'b1; mem_drv = KEEP;
      #1;
      chk({tag, "_ddt_released"}, DDT, KEEP);
      @(posedge clk); #1;
      chk({tag, "_resp_pulse"}, resp_valid, 0);
      chk({tag, "_ready_out"}, req_ready, 1);
   endtask

   typedef struct {
      logic        wr;
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          wt;
      logic [31:0] preload;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      int          exp_bus;
      logic [1:0]  exp_size;
      logic [31:0] exp_ddt;
   } vec_t;

   vec_t vecs [13];

   initial begin
      logic        wr, uns, mis, bad;
      logic [1:0]  sz, nsz;
      logic [31:0] addr, wd, erd;
      int          wt;

      vecs[0]  = '{1'b0, 2'b00, 1'b0, 32'h0800_0010, 32'h0,         0, 32'h1234_5678, 32'h1234_5678, 1'b0, 2, 1, 2'b00, 32'h0};
      vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h0800_0021, 32'h0,         1, 32'h0000_0080, 32'hffff_ff80, 1'b0, 3, 2, 2'b10, 32'h0};
      vecs[2]  = '{1'b0, 2'b10, 1'b1, 32'h0800_0021, 32'h0,         2, 32'h0000_0080, 32'h0000_0080, 1'b0, 4, 3, 2'b10, 32'h0};
      vecs[3]  = '{1'b0, 2'b01, 1'b0, 32'h0800_0006, 32'h0,         0, 32'h0000_8001, 32'hffff_8001, 1'b0, 2, 1, 2'b01, 32'h0};
      vecs[4]  = '{1'b0, 2'b01, 1'b1, 32'h0800_000a, 32'h0,         1, 32'h0000_8001, 32'h0000_8001, 1'b0, 3, 2, 2'b01, 32'h0};
      vecs[5]  = '{1'b1, 2'b10, 1'b0, 32'hf000_0000, 32'hdead_be41, 0, 32'h0,         32'h0,         1'b0, 2, 1, 2'b10, 32'h0000_0041};
      vecs[6]  = '{1'b1, 2'b01, 1'b0, 32'h0800_000c, 32'h1234_abcd, 1, 32'h0,         32'h0,         1'b0, 3, 2, 2'b01, 32'h0000_abcd};
      vecs[7]  = '{1'b1, 2'b00, 1'b0, 32'h0800_0014, 32'hcafe_f00d, 2, 32'h0,         32'h0,         1'b0, 4, 3, 2'b00, 32'hcafe_f00d};
      vecs[8]  = '{1'b0, 2'b00, 1'b0, 32'h0800_0002, 32'h0,         0, 32'h0,         32'h0,         1'b1, 1, 0, 2'b00, 32'h0};
      vecs[9]  = '{1'b1, 2'b01, 1'b0, 32'h0800_0003, 32'hffff_1234, 0, 32'h0,         32'h0,         1'b1, 1, 0, 2'b01, 32'h0};
      vecs[10] = '{1'b0, 2'b11, 1'b0, 32'h0800_0033, 32'h0,         0, 32'h0000_00ff, 32'hffff_ffff, 1'b0, 2, 1, 2'b10, 32'h0};
      vecs[11] = '{1'b1, 2'b00, 1'b0, 32'hff00_0004, 32'h0000_0001, 0, 32'h0,         32'h0,         1'b0, 2, 1, 2'b00, 32'h0000_0001};
      vecs[12] = '{1'b0, 2'b00, 1'b1, 32'h0800_0018, 32'h0,         0, 32'h8000_0000, 32'h8000_0000, 1'b0, 2, 1, 2'b00, 32'h0};

      for (int i = 0; i < 64; i++) begin
         mem[0][i] = 8'($urandom);
         mem[1][i] = mem[0][i];
      end

      rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = '0; ACKD_n = 1'b1; mem_oe = 1'b1; mem_drv = KEEP;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_mreq", MREQ, 0);
      chk("rst_write", WRITE, 0);
      chk("rst_size", SIZE, 0);
      chk("rst_dad", DAD, 0);
      chk("rst_ready", req_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_rdata", resp_rdata, 0);
      chk("rst_resp_err", resp_err, 0);
      chk("rst_ddt_released", DDT, KEEP);
      rst = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 13; i++) begin
         if (!vecs[i].wr) begin
            mem_put(0, vecs[i].addr, vecs[i].exp_size, vecs[i].preload);
            mem_put(1, vecs[i].addr, vecs[i].exp_size, vecs[i].preload);
         end
         run_xfer($sformatf("vec%0d", i), vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].addr,
                  vecs[i].wdata, vecs[i].wt, vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_lat,
                  vecs[i].exp_bus, vecs[i].exp_size, vecs[i].exp_ddt);
         if (vecs[i].wr && !vecs[i].exp_err)
            mem_put(0, vecs[i].addr, vecs[i].exp_size, vecs[i].wdata);
      end

      // No acknowledge at all: four bus cycles then an error response.
      run_xfer("timeout", 1'b0, 2'b00, 1'b0, 32'h0800_0020, 32'h0, 1000,
               32'h0, 1'b1, 5, 4, 2'b00, 32'h0);

      // Reset in the middle of a waiting transfer, then a stale low ACKD_n while idle.
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'h0800_0010; ACKD_n = 1'b1; mem_oe = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("abort_mreq_up", MREQ, 1);
      repeat (2) begin @(posedge clk); #1; end
      chk("abort_still_bus", MREQ, 1);
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      chk("abort_mreq", MREQ, 0);
      chk("abort_ready", req_ready, 1);
      chk("abort_no_resp", resp_valid, 0);
      ACKD_n = 1'b0;
      bad = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (resp_valid || MREQ) bad = 1'b1;
      end
      chk("stale_ack_ignored", bad, 0);
      ACKD_n = 1'b1;
      @(posedge clk); #1;

      for (int t = 0; t < 40; t++) begin
         wr   = 1'($urandom_range(0, 1));
         sz   = 2'($urandom_range(0, 3));
         uns  = 1'($urandom_range(0, 1));
         addr = 32'h0800_0000 | 32'($urandom_range(0, 63));
         wd   = $urandom;
         wt   = $urandom_range(0, 2);
         nsz  = (sz == 2'b11) ? 2'b10 : sz;
         mis  = (nsz == 2'b00 && addr[1:0] != 2'b00) || (nsz == 2'b01 && addr[0]);
         if (mis) begin
            run_xfer($sformatf("rnd%0d", t), wr, sz, uns, addr, wd, wt,
                     32'h0, 1'b1, 1, 0, nsz, 32'h0);
         end else begin
            erd = wr ? 32'h0 : ref_load(addr, nsz, uns);
            run_xfer($sformatf("rnd%0d", t), wr, sz, uns, addr, wd, wt,
                     erd, 1'b0, 2 + wt, 1 + wt, nsz, wd & mask_of(nbytes(nsz)));
            if (wr) mem_put(0, addr, nsz, wd);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
